// File: rtl/udp_payload_reducer.sv
// udp_payload_reducer: streaming SUM/MAX/MIN/COUNT reducer over UDP payload words, one result beat per packet
module udp_payload_reducer #(
    parameter int DATA_W     = 256,
    parameter int WORD_W     = 32,
    parameter int HDR_BEATS  = 1,
    parameter int OPCODE_LSB = 160,
    parameter int OPCODE_W   = 16,
    parameter int MAX_BEATS  = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic                              in_valid,
    input  logic                              in_last,
    input  logic [$clog2(DATA_W/WORD_W+1)-1:0] in_nwords,
    output logic                              in_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_err
);
    localparam int LANES     = DATA_W / WORD_W;
    localparam int NW_W      = $clog2(LANES + 1);
    localparam int OPC_LANES = OPCODE_LSB / WORD_W;
    localparam int BC_W      = $clog2(MAX_BEATS + 1);
    localparam logic [1:0] HDR = 2'd0, OPC = 2'd1, PAY = 2'd2;
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_BEATS);
    localparam logic [BC_W-1:0] BC_HDR = BC_W'(HDR_BEATS - 1);

    logic [1:0]          state;
    logic [BC_W-1:0]     beat_cnt;
    logic                pkt_over;
    logic [OPCODE_W-1:0] opc_q;
    logic                s1_valid, s1_first, s1_last, s1_err;
    logic [LANES-1:0]    s1_mask;
    logic [DATA_W-1:0]   s1_words;
    logic [OPCODE_W-1:0] s1_opc;
    logic [WORD_W-1:0]   acc_sum, acc_max, acc_min;
    logic [15:0]         acc_cnt;
    logic                skid_valid, skid_err;
    logic [DATA_W-1:0]   skid_data;

    logic                accept, out_free, stall, res_v, res_ok;
    logic [NW_W-1:0]     nw_eff;
    logic [LANES-1:0]    lane_m;
    logic [DATA_W-1:0]   in_masked, res_data;
    logic [WORD_W-1:0]   sum_b, max_b, min_b, nsum, nmax, nmin, sel, res_word;
    logic [15:0]         cnt_b, ncnt;
    logic [16:0]         cnt_sum;

    assign accept   = in_valid & in_ready;
    assign in_ready = !skid_valid;
    assign nw_eff   = (in_nwords == '0) ? NW_W'(LANES) : in_nwords;
    assign out_free = !out_valid | out_ready;
    // a finished result with both output register and skid full must wait in stage 1
    assign stall    = s1_valid & s1_last & skid_valid & !out_free;
    assign res_v    = s1_valid & s1_last & !stall;

    // select payload lanes of the incoming beat and zero the rest
    always_comb begin
        lane_m    = '0;
        in_masked = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_m[l] = (state == OPC) ? (l < OPC_LANES) && (!in_last || l < int'(nw_eff)) :
                        (state == PAY) ? (!in_last || l < int'(nw_eff)) : 1'b0;
            in_masked[l*WORD_W +: WORD_W] = lane_m[l] ? in_data[l*WORD_W +: WORD_W] : '0;
        end
    end

    // reduce stage-1 lanes and fold them into the running accumulator
    always_comb begin
        sum_b = '0;
        max_b = '0;
        min_b = '1;
        cnt_b = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_b = sum_b + s1_words[l*WORD_W +: WORD_W];
            max_b = (s1_mask[l] && s1_words[l*WORD_W +: WORD_W] > max_b) ? s1_words[l*WORD_W +: WORD_W] : max_b;
            min_b = (s1_mask[l] && s1_words[l*WORD_W +: WORD_W] < min_b) ? s1_words[l*WORD_W +: WORD_W] : min_b;
            cnt_b = cnt_b + {15'd0, s1_mask[l]};
        end
        nsum     = (s1_first ? '0 : acc_sum) + sum_b;
        nmax     = (!s1_first && acc_max > max_b) ? acc_max : max_b;
        nmin     = (!s1_first && acc_min < min_b) ? acc_min : min_b;
        cnt_sum  = {1'b0, s1_first ? 16'd0 : acc_cnt} + {1'b0, cnt_b};
        ncnt     = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        res_ok   = !s1_err && s1_opc >= OPCODE_W'(1) && s1_opc <= OPCODE_W'(4);
        sel      = (s1_opc == OPCODE_W'(1)) ? nsum :
                   (s1_opc == OPCODE_W'(2)) ? nmax :
                   (s1_opc == OPCODE_W'(3)) ? ((ncnt == 16'd0) ? '0 : nmin) : WORD_W'(ncnt);
        res_word = res_ok ? sel : '0;
        res_data = DATA_W'({ncnt, s1_opc, res_word});
    end

    // packet framing: header/opcode/payload phases, beat count and length violation
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= HDR;
            beat_cnt <= '0;
            pkt_over <= 1'b0;
            opc_q    <= '0;
        end else if (accept) begin
            state    <= in_last ? HDR : (state == HDR) ? ((beat_cnt == BC_HDR) ? OPC : HDR) : PAY;
            beat_cnt <= in_last ? '0 : (beat_cnt == BC_MAX) ? beat_cnt : beat_cnt + BC_W'(1);
            pkt_over <= !in_last & (pkt_over | (beat_cnt == BC_MAX));
            if (state == OPC) opc_q <= in_data[OPCODE_LSB +: OPCODE_W];
        end
    end

    // stage 1: register masked words and per-beat flags at the acceptance edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_err   <= 1'b0;
            s1_mask  <= '0;
            s1_words <= '0;
            s1_opc   <= '0;
        end else if (accept) begin
            s1_valid <= (state != HDR) | in_last;
            s1_first <= state != PAY;
            s1_last  <= in_last;
            s1_err   <= ((state == HDR) & in_last) | pkt_over | (beat_cnt == BC_MAX);
            s1_mask  <= lane_m;
            s1_words <= in_masked;
            s1_opc   <= (state == OPC) ? in_data[OPCODE_LSB +: OPCODE_W] : (state == PAY) ? opc_q : '0;
        end else if (!stall) begin
            s1_valid <= 1'b0;
        end
    end

    // stage 2: accumulator update, restarted by the first-payload flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_sum <= '0;
            acc_max <= '0;
            acc_min <= '0;
            acc_cnt <= '0;
        end else if (s1_valid && !stall) begin
            acc_sum <= nsum;
            acc_max <= nmax;
            acc_min <= nmin;
            acc_cnt <= ncnt;
        end
    end

    // output register with one-entry skid; skid drains first to keep results ordered
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else if (out_free) begin
            out_valid  <= skid_valid | res_v;
            out_data   <= skid_valid ? skid_data : res_v ? res_data : out_data;
            out_err    <= skid_valid ? skid_err : res_v ? !res_ok : out_err;
            skid_valid <= skid_valid & res_v;
            if (res_v) begin
                skid_data <= res_data;
                skid_err  <= !res_ok;
            end
        end else if (res_v) begin
            skid_valid <= 1'b1;
            skid_data  <= res_data;
            skid_err   <= !res_ok;
        end
    end
endmodule

// File: tb/tb_udp_payload_reducer.sv
// tb_udp_payload_reducer: randomized scoreboard bench for udp_payload_reducer with a word-list reference model
module tb_udp_payload_reducer;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [255:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [3:0]   in_nwords = '0;
    logic         in_ready;
    logic [255:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_err;

    typedef struct {
        logic [31:0] res;
        logic [15:0] opc;
        logic [15:0] cnt;
        logic        err;
        int          mode;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          rdy_mode = 2;
    int          dir_i = 0;
    logic [31:0] dir_w[7] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd10, 32'd20};

    udp_payload_reducer dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_nwords(in_nwords), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // downstream readiness: 0 random, 1 held low, 2 held high
    always @(posedge clk) begin
        #2;
        out_ready = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 2);
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // monitor: hold-stability while stalled, scoreboard compare on handshake
    logic [255:0] held_d;
    logic         held_e;
    logic         held_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held_d);
                chk("hold_err", out_err, held_e);
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_e = out_err;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got %0h want none", out_data);
                end else begin
                    e = sb.pop_front();
                    if (e.mode == 0) begin
                        chk("result", out_data, {192'd0, e.cnt, e.opc, e.res});
                        chk("err_clear", out_err, 0);
                    end else begin
                        chk("err_set", out_err, 1);
                        if (e.mode == 1) chk("err_result", out_data[31:0], 0);
                    end
                end
            end
        end
    end

    function automatic exp_t model(input logic [15:0] opc, input logic [31:0] w[$], input int nbeats);
        exp_t e;
        logic [31:0] s = 0, mx = 0, mn = 32'hFFFFFFFF;
        foreach (w[i]) begin
            s += w[i];
            if (w[i] > mx) mx = w[i];
            if (w[i] < mn) mn = w[i];
        end
        if (w.size() == 0) mn = 0;
        e.cnt  = 16'(w.size());
        e.opc  = opc;
        e.res  = (opc == 1) ? s : (opc == 2) ? mx : (opc == 3) ? mn : (opc == 4) ? 32'(w.size()) : 32'd0;
        e.err  = !(opc inside {[1:4]}) || nbeats > 64;
        e.mode = (nbeats > 64) ? 2 : e.err ? 1 : 0;
        return e;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] gen(input int fill);
        logic [31:0] v;
        if (fill == 1) v = 32'hFFFFFFFF;
        else if (fill == 2) begin
            v = dir_w[dir_i];
            dir_i++;
        end else v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        return v;
    endfunction

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send_beat(input logic [255:0] d, input logic l, input logic [3:0] nw);
        int n = 0;
        in_data = d;
        in_last = l;
        in_nwords = nw;
        in_valid = 1'b1;
        while (!in_ready) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                $display("FAIL in_ready_timeout: got 0 want 1");
                bad++;
                total++;
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "stuck");
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // npay = beats after the header, opcode beat included
    task automatic send_pkt(input logic [15:0] opc, input int npay, input logic [3:0] nw, input int fill, input int gap);
        logic [31:0]  w[$];
        logic [255:0] beats[$];
        logic [255:0] d;
        logic [31:0]  v;
        int n, k;
        dir_i = 0;
        beats.push_back(rand256());
        for (int b = 0; b < npay; b++) begin
            d = rand256();
            if (b == 0) d[160 +: 16] = opc;
            n = (b == 0) ? 5 : 8;
            if (b == npay - 1) begin
                k = (nw == 0) ? 8 : int'(nw);
                if (k < n) n = k;
            end
            for (int i = 0; i < n; i++) begin
                v = gen(fill);
                d[i*32 +: 32] = v;
                w.push_back(v);
            end
            beats.push_back(d);
        end
        sb.push_back(model(opc, w, npay + 1));
        for (int i = 0; i < beats.size(); i++) begin
            send_beat(beats[i], i == beats.size() - 1, (i == beats.size() - 1) ? nw : 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, gap)) @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 256'(sb.size()), 0);
    endtask

    initial begin
        exp_t e;
        logic [255:0] d;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b1;
        @(negedge clk);

        send_pkt(16'd1, 2, 4'd2, 2, 0);
        chk("lat_edge0", out_valid, 0);
        @(negedge clk);
        chk("lat_edge1", out_valid, 1);
        send_pkt(16'd2, 2, 4'd2, 2, 0);
        send_pkt(16'd3, 2, 4'd2, 2, 0);
        send_pkt(16'd4, 2, 4'd2, 2, 0);
        send_pkt(16'd9, 2, 4'd2, 2, 0);
        send_pkt(16'd1, 2, 4'd3, 1, 0);
        drain();

        rdy_mode = 1;
        repeat (2) @(negedge clk);
        send_pkt(16'd1, 1, 4'd0, 0, 0);
        send_pkt(16'd2, 1, 4'd0, 0, 0);
        fork
            send_pkt(16'd3, 1, 4'd0, 0, 0);
            begin
                repeat (12) @(negedge clk);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_pending", 256'(sb.size()), 3);
                rdy_mode = 2;
            end
        join
        drain();

        e.res = 0; e.opc = 0; e.cnt = 0; e.err = 1; e.mode = 2;
        sb.push_back(e);
        send_beat(rand256(), 1'b1, 4'd0);
        send_pkt(16'd4, 2, 4'd3, 0, 1);
        send_pkt(16'd1, 69, 4'd0, 0, 0);
        send_pkt(16'd2, 2, 4'd5, 0, 0);
        drain();

        send_beat(rand256(), 1'b0, 4'd0);
        d = rand256();
        d[160 +: 16] = 16'd1;
        send_beat(d, 1'b0, 4'd0);
        send_beat(rand256(), 1'b0, 4'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_output", out_valid, 0);
        send_pkt(16'd1, 3, 4'd4, 0, 0);
        drain();

        rdy_mode = 0;
        for (int p = 0; p < 40; p++) begin
            int npay;
            logic [15:0] opc;
            npay = $urandom_range(1, 6);
            opc = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(1, 4)) : 16'($urandom_range(0, 15));
            send_pkt(opc, npay, (npay == 1) ? 4'd0 : 4'($urandom_range(0, 8)), 0, 2);
        end
        rdy_mode = 2;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
